// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and hazard_ctrl.
// master = pipeline side (drives hazard inputs), slave = hazard_ctrl.
interface hazard_ctrl_if;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [2:0]  ex_rs;
    logic [2:0]  ex_rt;
    logic [2:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_multicycle;
    logic        mem_regwrite;
    logic [2:0]  mem_rd;
    logic        wb_regwrite;
    logic [2:0]  wb_rd;
    logic        branch_taken;

    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_write;
    logic        idex_bubble;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        busy;
    logic [15:0] stall_count;
    logic        dbg_state;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_rd,
               ex_regwrite, ex_memread, ex_multicycle, mem_regwrite, mem_rd,
               wb_regwrite, wb_rd, branch_taken,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               fwd_a, fwd_b, busy, stall_count, dbg_state
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_rd,
               ex_regwrite, ex_memread, ex_multicycle, mem_regwrite, mem_rd,
               wb_regwrite, wb_rd, branch_taken,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               fwd_a, fwd_b, busy, stall_count, dbg_state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// ID/EX hazard controller: load-use / RAW stalls, multi-cycle EX hold, branch flush,
// EX operand forwarding (macro HAZARD_FWD_EN) and a saturating stall counter.
module hazard_ctrl #(
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 4
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave hz
);
    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      stall_count_q, stall_count_d;

    logic lu, raw, mc, mchold, branch_run;
    logic pc_write_c, ifid_write_c, ifid_flush_c, idex_write_c, idex_bubble_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    function automatic logic reads_reg(input logic [2:0] r, input logic [2:0] rs,
                                       input logic [2:0] rt, input logic use_rs,
                                       input logic use_rt);
        return (use_rs && (rs == r)) || (use_rt && (rt == r));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [2:0] src, input logic mem_we,
                                           input logic [2:0] mem_rd, input logic wb_we,
                                           input logic [2:0] wb_rd);
        if (mem_we && (mem_rd == src)) return 2'b10;
        if (wb_we && (wb_rd == src))   return 2'b01;
        return 2'b00;
    endfunction

    assign lu = hz.ex_memread &&
                reads_reg(hz.ex_rd, hz.id_rs, hz.id_rt, hz.id_use_rs, hz.id_use_rt);

`ifdef HAZARD_FWD_EN
    logic unused_sigs;
    assign unused_sigs = hz.ex_regwrite;
    assign raw     = 1'b0;
    assign fwd_a_c = fwd_sel(hz.ex_rs, hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd);
    assign fwd_b_c = fwd_sel(hz.ex_rt, hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd);
`else
    // Register file is write-first, so a WB-stage producer never needs a stall.
    logic unused_sigs;
    assign unused_sigs = ^{hz.ex_rs, hz.ex_rt, hz.wb_regwrite, hz.wb_rd};
    assign raw = (hz.ex_regwrite &&
                  reads_reg(hz.ex_rd, hz.id_rs, hz.id_rt, hz.id_use_rs, hz.id_use_rt)) ||
                 (hz.mem_regwrite &&
                  reads_reg(hz.mem_rd, hz.id_rs, hz.id_rt, hz.id_use_rs, hz.id_use_rt));
    assign fwd_a_c = 2'b00;
    assign fwd_b_c = 2'b00;
`endif

    assign mc         = (state_q == RUN) && hz.ex_multicycle;
    assign mchold     = (state_q == MC_WAIT) && (cnt_q != CNT_ONE);
    assign branch_run = (state_q == RUN) && hz.branch_taken;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_write_c  = 1'b1;
        idex_bubble_c = 1'b0;

        if (branch_run) begin
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
        end else if (mc || mchold) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            idex_write_c = 1'b0;
        end else if (lu || raw) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
        end

        // The release cycle (cnt==1) is already a non-stall cycle; RUN takes over next edge.
        if (mc) begin
            state_d = MC_WAIT;
            cnt_d   = CNT_LOAD;
        end else if (state_q == MC_WAIT) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = RUN;
        end

        stall_count_d = stall_count_q;
        if (!pc_write_c && (stall_count_q != 16'hFFFF))
            stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    // While reset is held the pipeline is filled with NOPs.
    assign hz.pc_write    = rst_n ? pc_write_c    : 1'b0;
    assign hz.ifid_write  = rst_n ? ifid_write_c  : 1'b0;
    assign hz.ifid_flush  = rst_n ? ifid_flush_c  : 1'b1;
    assign hz.idex_write  = rst_n ? idex_write_c  : 1'b1;
    assign hz.idex_bubble = rst_n ? idex_bubble_c : 1'b1;
    assign hz.fwd_a       = rst_n ? fwd_a_c       : 2'b00;
    assign hz.fwd_b       = rst_n ? fwd_b_c       : 2'b00;
    assign hz.busy        = rst_n && (state_q == MC_WAIT);
    assign hz.stall_count = stall_count_q;
    assign hz.dbg_state   = state_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle-level behavioural model checked every
// negedge, plus literal expectations at the interesting cycles.
module tb_hazard_ctrl;
    localparam int MC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if bus();

    hazard_ctrl #(.MC_CYCLES(MC), .CNT_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (bus)
    );

    typedef struct packed {
        logic       pc_write;
        logic       ifid_write;
        logic       ifid_flush;
        logic       idex_write;
        logic       idex_bubble;
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
        logic       busy;
    } ctl_t;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Model state: position of the current multi-cycle op inside its EX occupancy
    // window (0..MC-1), -1 when none, plus the expected stall count.
    int m_prev_occ = -1;
    int m_stalls = 0;

    function automatic logic reads(input logic [2:0] r);
        return (bus.id_use_rs && bus.id_rs == r) || (bus.id_use_rt && bus.id_rt == r);
    endfunction

    function automatic logic [1:0] fsel(input logic [2:0] r);
        if (bus.mem_regwrite && bus.mem_rd == r) return 2'b10;
        if (bus.wb_regwrite && bus.wb_rd == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int model_occ();
        if (m_prev_occ >= 0 && m_prev_occ < MC - 1) return m_prev_occ + 1;
        if (bus.ex_multicycle) return 0;
        return -1;
    endfunction

    function automatic ctl_t model_ctl();
        ctl_t c;
        int occ;
        logic hz_load, hz_raw;
        c = '0;
        if (!rst_n) begin
            c.idex_write = 1'b1;
            c.ifid_flush = 1'b1;
            c.idex_bubble = 1'b1;
            return c;
        end
        occ = model_occ();
        hz_load = bus.ex_memread && reads(bus.ex_rd);
`ifdef HAZARD_FWD_EN
        hz_raw = 1'b0;
        c.fwd_a = fsel(bus.ex_rs);
        c.fwd_b = fsel(bus.ex_rt);
`else
        hz_raw = (bus.ex_regwrite && reads(bus.ex_rd)) ||
                 (bus.mem_regwrite && reads(bus.mem_rd));
`endif
        c.busy = (occ >= 1);
        // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble}
        if (bus.branch_taken && occ <= 0)
            {c.pc_write, c.ifid_write, c.ifid_flush, c.idex_write, c.idex_bubble} = 5'b11111;
        else if (occ >= 0 && occ <= MC - 2)
            {c.pc_write, c.ifid_write, c.ifid_flush, c.idex_write, c.idex_bubble} = 5'b00000;
        else if (hz_load || hz_raw)
            {c.pc_write, c.ifid_write, c.ifid_flush, c.idex_write, c.idex_bubble} = 5'b00011;
        else
            {c.pc_write, c.ifid_write, c.ifid_flush, c.idex_write, c.idex_bubble} = 5'b11010;
        return c;
    endfunction

    function automatic logic model_stalls_now();
        ctl_t c;
        c = model_ctl();
        return !c.pc_write;
    endfunction

    function automatic ctl_t dut_ctl();
        ctl_t c;
        c.pc_write = bus.pc_write;
        c.ifid_write = bus.ifid_write;
        c.ifid_flush = bus.ifid_flush;
        c.idex_write = bus.idex_write;
        c.idex_bubble = bus.idex_bubble;
        c.fwd_a = bus.fwd_a;
        c.fwd_b = bus.fwd_b;
        c.busy = bus.busy;
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev_occ <= -1;
            m_stalls <= 0;
        end else begin
            if (model_stalls_now() && m_stalls < 65535) m_stalls <= m_stalls + 1;
            m_prev_occ <= model_occ();
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (chk_en) begin
            n_vec++;
            if (dut_ctl() !== model_ctl()) begin
                n_bad++;
                $display("FAIL ctl cyc=%0d got=%b expected=%b (pc,ifw,fl,idw,bub,fa,fb,busy)",
                         cyc, dut_ctl(), model_ctl());
            end
            n_vec++;
            if (bus.stall_count !== 16'(m_stalls)) begin
                n_bad++;
                $display("FAIL stall_count cyc=%0d got=%0d expected=%0d",
                         cyc, bus.stall_count, m_stalls);
            end
        end
    end

    task automatic lit(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] id_rs, input logic [2:0] id_rt,
                         input logic use_rs, input logic use_rt,
                         input logic [2:0] ex_rs, input logic [2:0] ex_rt,
                         input logic [2:0] ex_rd, input logic ex_rw, input logic ex_mr,
                         input logic ex_mc, input logic mem_rw, input logic [2:0] mem_rd,
                         input logic wb_rw, input logic [2:0] wb_rd, input logic br);
        bus.id_rs = id_rs;           bus.id_rt = id_rt;
        bus.id_use_rs = use_rs;      bus.id_use_rt = use_rt;
        bus.ex_rs = ex_rs;           bus.ex_rt = ex_rt;
        bus.ex_rd = ex_rd;           bus.ex_regwrite = ex_rw;
        bus.ex_memread = ex_mr;      bus.ex_multicycle = ex_mc;
        bus.mem_regwrite = mem_rw;   bus.mem_rd = mem_rd;
        bus.wb_regwrite = wb_rw;     bus.wb_rd = wb_rd;
        bus.branch_taken = br;
    endtask

    task automatic idle();
        drive(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0,
              1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        mid();
        nxt();
    endtask

`ifdef HAZARD_FWD_EN
    localparam int RAW_STALLS = 0;
`else
    localparam int RAW_STALLS = 1;
`endif

    initial begin
        idle();
        rst_n = 1'b0;
        chk_en = 1'b1;

        // Reset held for three cycles
        repeat (3) begin
            mid();
            lit("rst_pc_write", 16'(bus.pc_write), 16'h0);
            lit("rst_ifid_flush", 16'(bus.ifid_flush), 16'h1);
            lit("rst_idex_bubble", 16'(bus.idex_bubble), 16'h1);
            nxt();
        end
        lit("rst_stall_count", bus.stall_count, 16'h0);
        rst_n = 1'b1;
        mid();
        lit("idle_writes", 16'({bus.pc_write, bus.ifid_write, bus.idex_write}), 16'h7);
        nxt();

        // Load-use on rs = r3: one bubble
        drive(3'd3, 3'd0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0,
              1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        mid();
        lit("lu_pc_write", 16'(bus.pc_write), 16'h0);
        lit("lu_bubble", 16'(bus.idex_bubble), 16'h1);
        nxt();
        idle();
        mid();
        lit("lu_stall_count", bus.stall_count, 16'd1);
        lit("lu_after_pc_write", 16'(bus.pc_write), 16'h1);
        nxt();

        // Multi-cycle op held in ID/EX for MC cycles
        drive(3'd0, 3'd0, 1'b0, 1'b0, 3'd1, 3'd2, 3'd4, 1'b1, 1'b0, 1'b1,
              1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < MC; i++) begin
            mid();
            lit("mc_idex_write", 16'(bus.idex_write), (i < MC - 1) ? 16'h0 : 16'h1);
            lit("mc_busy", 16'(bus.busy), (i >= 1) ? 16'h1 : 16'h0);
            nxt();
        end
        idle();
        mid();
        lit("mc_stall_count", bus.stall_count, 16'd4);
        lit("mc_busy_done", 16'(bus.busy), 16'h0);
        nxt();

        // Taken branch overrides a load-use match; no stall counted
        drive(3'd3, 3'd0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0,
              1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
        mid();
        lit("br_ctl", 16'({bus.ifid_flush, bus.idex_bubble, bus.pc_write}), 16'h7);
        nxt();
        idle();
        mid();
        lit("br_stall_count", bus.stall_count, 16'd4);
        nxt();

`ifdef HAZARD_FWD_EN
        drive(3'd0, 3'd0, 1'b0, 1'b0, 3'd5, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0,
              1'b1, 3'd5, 1'b1, 3'd5, 1'b0);
        mid();
        lit("fwd_a_mem_wins", 16'(bus.fwd_a), 16'h2);
        lit("fwd_b_none", 16'(bus.fwd_b), 16'h0);
        nxt();
        drive(3'd0, 3'd0, 1'b0, 1'b0, 3'd5, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0,
              1'b0, 3'd5, 1'b1, 3'd5, 1'b0);
        mid();
        lit("fwd_a_wb", 16'(bus.fwd_a), 16'h1);
        lit("fwd_b_wb", 16'(bus.fwd_b), 16'h1);
        nxt();
`endif

        // MEM-stage producer of rt = r2
        drive(3'd0, 3'd2, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0,
              1'b1, 3'd2, 1'b0, 3'd0, 1'b0);
        mid();
        lit("raw_pc_write", 16'(bus.pc_write), RAW_STALLS ? 16'h0 : 16'h1);
        lit("raw_fwd_b", 16'(bus.fwd_b), 16'h0);
        nxt();
        idle();
        mid();
        lit("raw_stall_count", bus.stall_count, 16'(4 + RAW_STALLS));
        nxt();

        // Model-checked directed vectors
        // WB producer only: never a stall
        drive(3'd6, 3'd1, 1'b1, 1'b1, 3'd6, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0,
              1'b0, 3'd3, 1'b1, 3'd6, 1'b0); cycle();
        // Matching register not actually read
        drive(3'd3, 3'd3, 1'b0, 1'b0, 3'd3, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0,
              1'b1, 3'd3, 1'b1, 3'd3, 1'b0); cycle();
        // EX-stage producer (non-load), r0 match
        drive(3'd0, 3'd7, 1'b1, 1'b0, 3'd0, 3'd7, 3'd0, 1'b1, 1'b0, 1'b0,
              1'b1, 3'd0, 1'b1, 3'd7, 1'b0); cycle();
        // Load-use through rt
        drive(3'd1, 3'd7, 1'b1, 1'b1, 3'd2, 3'd4, 3'd7, 1'b0, 1'b1, 1'b0,
              1'b0, 3'd0, 1'b1, 3'd4, 1'b0); cycle();
        idle(); cycle();
        // Multi-cycle op with a spurious branch while busy, load-use at release
        drive(3'd0, 3'd0, 1'b0, 1'b0, 3'd1, 3'd2, 3'd5, 1'b1, 1'b0, 1'b1,
              1'b0, 3'd0, 1'b0, 3'd0, 1'b0); cycle();
        bus.branch_taken = 1'b1; cycle();
        bus.branch_taken = 1'b0; cycle();
        bus.ex_memread = 1'b1; bus.id_rs = 3'd5; bus.id_use_rs = 1'b1; cycle();
        idle(); cycle();

        // Reset asserted in the middle of a multi-cycle op aborts it
        drive(3'd0, 3'd0, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 1'b1,
              1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        lit("rst_mid_busy", 16'(bus.busy), 16'h0);
        lit("rst_mid_count", bus.stall_count, 16'h0);
        mid();
        idle();
        nxt();
        rst_n = 1'b1;
        mid();
        lit("post_rst_pc_write", 16'(bus.pc_write), 16'h1);
        lit("post_rst_busy", 16'(bus.busy), 16'h0);
        nxt();
        cycle();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the ID/EX boundary of the 19-bit CPU. Each cycle it decides whether the IF/ID and ID/EX registers load, hold, or take a bubble, and it selects EX-stage operand forwarding. It resolves load-use hazards, multi-cycle EX operations and taken-branch flushes. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- `MC_CYCLES`, default 4: total EX occupancy of a multi-cycle op. Legal range 2..15.
- `CNT_W`, default 4: width of the multi-cycle counter. Must satisfy 2^CNT_W > MC_CYCLES.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_rs`, `id_rt` in 3 each: source registers of the instruction in ID.
- `id_use_rs`, `id_use_rt` in 1 each: the ID instruction reads rs / rt.
- `ex_rs`, `ex_rt` in 3 each: source registers held in ID/EX.
- `ex_rd` in 3: EX destination, after the regdist mux.
- `ex_regwrite`, `ex_memread`, `ex_multicycle` in 1 each: EX control bits.
- `mem_regwrite` in 1, `mem_rd` in 3: EX/MEM destination.
- `wb_regwrite` in 1, `wb_rd` in 3: MEM/WB destination.
- `branch_taken` in 1: branch resolved as taken in EX this cycle.
- `pc_write` out 1: PC loads.
- `ifid_write` out 1: IF/ID loads.
- `ifid_flush` out 1: IF/ID loads a NOP.
- `idex_write` out 1: ID/EX loads.
- `idex_bubble` out 1: ID/EX loads all-zero control.
- `fwd_a`, `fwd_b` out 2 each: EX operand source. 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- `busy` out 1: FSM is in MC_WAIT.
- `stall_count` out 16: stall cycles since reset, saturating.

## Operation
- **FSM states:** RUN (0), MC_WAIT (1). The state register is `state`; the counter register is `cnt` (CNT_W bits).
- **Hazard terms.** All are combinational. "Match" means equal 3-bit numbers; r0 gets no special treatment.
  - `lu`: `ex_memread` && `ex_rd` matches a used ID source.
  - `raw`: `ex_regwrite`/`ex_rd` or `mem_regwrite`/`mem_rd` matches a used ID source. Evaluated only without `HAZARD_FWD_EN`.
  - `mc`: state==RUN && `ex_multicycle`.
  - `mchold`: state==MC_WAIT && `cnt`!=1.
- **Priority, highest first:**
  1. `branch_taken`, in RUN only: `ifid_flush`=1, `idex_bubble`=1, `pc_write`=1, `idex_write`=1. This overrides `lu` and `raw`.
  2. `mc` or `mchold`: `pc_write`=0, `ifid_write`=0, `idex_write`=0, `idex_bubble`=0. ID/EX holds the op.
  3. `lu` or `raw`: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1, `idex_write`=1.
  4. Otherwise: all write enables are 1, and `ifid_flush` and `idex_bubble` are 0.
- **Transitions:**
  - RUN to MC_WAIT when `mc`, loading `cnt`=MC_CYCLES-1.
  - In MC_WAIT, `cnt` decrements every cycle.
  - When `cnt`==1, the stall releases that same cycle and the FSM goes to RUN.
  - Any other case holds the current state.
- `branch_taken` in MC_WAIT cannot occur; it is ignored there.
- **Forwarding, `fwd_a` on `ex_rs`:**
  - 10 if `mem_regwrite` and `mem_rd`==`ex_rs`.
  - Else 01 if `wb_regwrite` and `wb_rd`==`ex_rs`.
  - Else 00.
  - EX/MEM wins when both match.
  - `fwd_b` is identical on `ex_rt`.
- **`stall_count`:**
  - Increments by 1 in each cycle where `pc_write`=0.
  - Saturates at 16'hFFFF.

## Timing
- Control outputs are Mealy: combinational from the current inputs plus `state`/`cnt`. There is zero-cycle latency from hazard to stall.
- **Reset (`rst_n` low), asynchronous:**
  - `state`=RUN, `cnt`=0, `stall_count`=0.
  - Outputs are forced to `pc_write`=0, `ifid_write`=0, `idex_write`=1, `ifid_flush`=1, `idex_bubble`=1, `fwd_a`/`fwd_b`=00, `busy`=0.
  - The pipeline therefore fills with NOPs while reset is held.
  - Reset asserted mid-MC_WAIT aborts the op immediately.
- **Multi-cycle op:**
  - Detected in cycle N.
  - Stall is asserted in cycles N..N+MC_CYCLES-2.
  - Release happens in N+MC_CYCLES-1, and the op occupies EX for exactly MC_CYCLES cycles.
- **Load-use:**
  - Exactly one bubble cycle.
  - The next cycle the load is in MEM and forwarding selects 01 once it reaches WB.
- Counter and state update on the rising edge of `clk`.

## Configuration
- `HAZARD_FWD_EN`:
  - **Defined:** the forwarding logic is built and `raw` is constant 0.
  - **Undefined:** `fwd_a`/`fwd_b` are tied to 00 and `raw` stalls are enabled. The register file is write-first, so a match with WB needs no stall.

## Test plan
- Reset held 3 cycles → outputs are `pc_write`=0, `ifid_flush`=1, `idex_bubble`=1; `stall_count`=0. After release, with idle inputs, all write enables are 1.
- Load-use: `ex_memread`=1, `ex_rd`=3, `id_rs`=3, `id_use_rs`=1 → exactly one cycle of `pc_write`=0, `idex_bubble`=1. `stall_count` goes 0→1.
- MC op with MC_CYCLES=4: `ex_multicycle`=1 at cycle N → `idex_write`=0 in N, N+1 and N+2; `busy`=1 in N+1..N+3; release in N+3. `stall_count`=3.
- Branch: `branch_taken`=1 together with a load-use match → `ifid_flush`=1, `idex_bubble`=1, `pc_write`=1. No stall is counted.
- Forwarding (FWD_EN): `mem_rd`=`wb_rd`=`ex_rs`=5, both regwrites =1 → `fwd_a`=10. With `mem_regwrite`=0 → `fwd_a`=01.
- Without FWD_EN: `mem_regwrite`=1, `mem_rd`=2, `id_rt`=2, `id_use_rt`=1 → one bubble cycle and `fwd_b`=00.
